// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares a single memory request/response port between the instruction-fetch
//   requester (imem) and the load/store requester (dmem). Requests are granted
//   with dmem priority. A grant that stalls on m_req_ready is held until its
//   handshake completes. Each accepted request pushes its requester id into an
//   ordered tag FIFO. The in-order memory responses pop that FIFO and are
//   steered back to the requester that issued them, with zero latency.
//
// Optional feature (macro ARB_STARVE_GUARD_EN):
//   A saturating counter records the cycles imem loses arbitration. When it
//   reaches STARVE_LIMIT, imem wins the next unlocked selection. Without the
//   macro, dmem always has strict priority and the counter is not built.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   i_req_* / d_req_*     imem / dmem request channels (valid/ready handshake,
//                         addr, fcn 0=read 1=write, typ access mask, wdata)
//   i_res_* / d_res_*     imem / dmem response valid + data
//   m_req_*               muxed request to the memory port
//   m_res_valid/data      in-order memory responses, one per accepted request
//   err_spurious          sticky flag: response arrived with no tag outstanding
module memory_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_fcn,
  input  logic [2:0]        i_req_typ,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              i_res_valid,
  output logic [DATA_W-1:0] i_res_data,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_fcn,
  input  logic [2:0]        d_req_typ,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_res_valid,
  output logic [DATA_W-1:0] d_res_data,

  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic              m_req_fcn,
  output logic [2:0]        m_req_typ,
  output logic [DATA_W-1:0] m_req_wdata,
  input  logic              m_res_valid,
  input  logic [DATA_W-1:0] m_res_data,

  output logic              err_spurious
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // Elaboration-time parameter sanity checks.
  if (MAX_OUTSTANDING < 1 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("memory_port_arbiter: MAX_OUTSTANDING must be a power of two >= 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("memory_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    GRANT_OPEN      = 2'd0,
    GRANT_HELD_IMEM = 2'd1,
    GRANT_HELD_DMEM = 2'd2
  } grant_state_t;

  grant_state_t               grant_state, grant_next;
  req_id_t                    sel;
  logic                       sel_valid;
  logic                       handshake;
  logic                       push, pop;
  logic                       force_imem;

  logic [CNT_W-1:0]           count;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] tag_mem;

  // Requester selection, issue gating and the grant-hold state machine.
  // A held grant overrides both the normal priority and the starvation guard,
  // so the payload on m_req_* stays stable while memory back-pressures.
  always_comb begin
    sel        = d_req_valid ? REQ_DMEM : REQ_IMEM;
    grant_next = GRANT_OPEN;

    if (force_imem) begin
      sel = REQ_IMEM;
    end

    case (grant_state)
      GRANT_HELD_IMEM: sel = REQ_IMEM;
      GRANT_HELD_DMEM: sel = REQ_DMEM;
      default:         ;
    endcase

    sel_valid = (sel == REQ_DMEM) ? d_req_valid : i_req_valid;

    // Full check uses the registered count, so a same-cycle pop does not free
    // a slot until the following cycle.
    m_req_valid = reset && sel_valid && (count < CNT_MAX);
    handshake   = m_req_valid && m_req_ready;

    i_req_ready = handshake && (sel == REQ_IMEM);
    d_req_ready = handshake && (sel == REQ_DMEM);

    if (sel == REQ_DMEM) begin
      m_req_addr  = d_req_addr;
      m_req_fcn   = d_req_fcn;
      m_req_typ   = d_req_typ;
      m_req_wdata = d_req_wdata;
    end else begin
      m_req_addr  = i_req_addr;
      m_req_fcn   = i_req_fcn;
      m_req_typ   = i_req_typ;
      m_req_wdata = i_req_wdata;
    end

    if (m_req_valid && !m_req_ready) begin
      grant_next = (sel == REQ_DMEM) ? GRANT_HELD_DMEM : GRANT_HELD_IMEM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_state <= GRANT_OPEN;
    end else begin
      grant_state <= grant_next;
    end
  end

  // Response steering: the head tag names the requester that owns the
  // response currently on m_res_*.
  assign push        = handshake;
  assign pop         = reset && m_res_valid && (count != '0);
  assign i_res_valid = pop && !tag_mem[rd_ptr];
  assign d_res_valid = pop &&  tag_mem[rd_ptr];
  assign i_res_data  = m_res_data;
  assign d_res_data  = m_res_data;

  // Ordered tag FIFO plus the sticky spurious-response flag. Reset discards
  // every outstanding tag, so late responses are reported as spurious.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_mem      <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (m_res_valid && (count == '0)) begin
        err_spurious <= 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0] starve_cnt;

  // Counts cycles imem is waiting while the selection points at dmem. The
  // count saturates, and it clears only when imem actually handshakes. This
  // keeps the boost active across full-FIFO cycles until the grant lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (i_req_ready) begin
      starve_cnt <= '0;
    end else if (i_req_valid && (sel == REQ_DMEM) && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  assign force_imem = i_req_valid && (starve_cnt == STARVE_MAX);
`else
  assign force_imem = 1'b0;
`endif

endmodule
